// File: rtl/fetch_sequencer.sv
// Instruction sequencer: owns the PC, fetches/decodes ROM words, resolves jmp/br locally
// and issues everything else to the datapath. Optional HALT on self-jmp: FETCH_SEQ_HALT_DETECT_EN.
module fetch_sequencer #(
  parameter int ADDR_W = 4,
  parameter int INST_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  input  logic              zero_flag,
  output logic              issue_valid,
  output logic [INST_W-1:0] issue_inst,
  input  logic              issue_ready,
  input  logic              exec_done,
  output logic              busy,
  output logic              halted
);

  localparam logic [3:0] OP_JMP = 4'b1000;
  localparam logic [3:0] OP_BR  = 4'b1100;
  // Branch targets come from IR[11:8]; narrower PCs keep only the low bits.
  localparam int TGT_W = (ADDR_W < 4) ? ADDR_W : 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_EXEC
`ifdef FETCH_SEQ_HALT_DETECT_EN
    , S_HALT
`endif
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [INST_W-1:0] ir;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_inc;

  assign opcode   = ir[INST_W-1 -: 4];
  assign target   = ADDR_W'(ir[8 +: TGT_W]);
  assign pc_inc   = pc + ADDR_W'(1);
  assign rom_addr = pc;

`ifdef FETCH_SEQ_HALT_DETECT_EN
  logic halted_q;
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  // NOTE: every register here is updated with <= so all state moves together on
  // the edge; a blocking = would let later statements see half-updated values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      ir          <= '0;
      issue_valid <= 1'b0;
      issue_inst  <= '0;
      busy        <= 1'b0;
`ifdef FETCH_SEQ_HALT_DETECT_EN
      halted_q    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            state <= S_FETCH;
            busy  <= 1'b1;
          end
        end

        S_FETCH: begin
          ir    <= rom_inst;
          state <= S_DECODE;
        end

        S_DECODE: begin
          if (opcode == OP_JMP) begin
            pc <= target;
`ifdef FETCH_SEQ_HALT_DETECT_EN
            if (target == pc) begin
              state    <= S_HALT;
              busy     <= 1'b0;
              halted_q <= 1'b1;
            end else
`endif
            begin
              state <= run ? S_FETCH : S_IDLE;
              busy  <= run;
            end
          end else if (opcode == OP_BR) begin
            pc    <= zero_flag ? target : pc_inc;
            state <= run ? S_FETCH : S_IDLE;
            busy  <= run;
          end else begin
            // Unknown opcodes go out unmodified; the datapath owns their meaning.
            issue_valid <= 1'b1;
            issue_inst  <= ir;
            state       <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (issue_ready) begin
            issue_valid <= 1'b0;
            state       <= S_EXEC;
          end
        end

        S_EXEC: begin
          // Completion only counts once we are here, never on the accept edge.
          if (exec_done) begin
            pc    <= pc_inc;
            state <= run ? S_FETCH : S_IDLE;
            busy  <= run;
          end
        end

`ifdef FETCH_SEQ_HALT_DETECT_EN
        S_HALT: begin
          state <= S_HALT;
        end
`endif

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction sequencer for the 16-entry program ROM: owns the program counter, drives the ROM address, and fetches and decodes each 16-bit instruction.
- Resolves jmp and br internally.
- Issues all other instructions (load, add, sub, subi, mov, out) to the execute datapath over a valid/ready handshake, then waits for completion.
- Sits between the program ROM and the register-file/ALU datapath.

Parameters:
- ADDR_W, 4, PC and ROM address width; the PC wraps modulo 2^ADDR_W.
- INST_W, 16, instruction width; opcode is inst[INST_W-1:INST_W-4].

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  level enable; when low, the sequencer parks in IDLE at the next instruction boundary.
- rom_addr  output  ADDR_W  ROM address; equals the PC register.
- rom_inst  input  INST_W  ROM read data; combinational from rom_addr.
- zero_flag  input  1  datapath zero flag; sampled in DECODE for br.
- issue_valid  output  1  issue_inst is valid for the datapath.
- issue_inst  output  INST_W  instruction being issued.
- issue_ready  input  1  datapath accepts issue_inst.
- exec_done  input  1  one-cycle pulse: the datapath finished the issued instruction.
- busy  output  1  high in every state except IDLE and HALT.
- halted  output  1  high in HALT; constant 0 when HALT_DETECT_EN is undefined.

Behaviour:
- Reset values: PC=0, IR=0, state=IDLE, issue_valid=0, issue_inst=0, busy=0, halted=0.
- Reset asserted mid-operation returns all of the above to reset values at the next edge. Any pending issue is dropped; no exec_done is awaited.

State transitions:
- IDLE: if run, go to FETCH; otherwise stay.
- FETCH: IR <= rom_inst (ROM address is the PC); go to DECODE.
- DECODE, opcode 1000 (jmp): PC <= IR[11:8]; go to FETCH if run, else IDLE.
- DECODE, opcode 1100 (br): if zero_flag, PC <= IR[11:8], else PC <= PC+1; go to FETCH if run, else IDLE.
- DECODE, any other opcode: go to ISSUE. Unknown opcodes are issued unmodified; the datapath decides what they do.
- ISSUE: issue_valid=1 and issue_inst=IR. Both are held stable until issue_ready is sampled high. On that edge, go to EXEC; issue_valid is 0 from the next cycle.
- EXEC: wait for exec_done. On exec_done, PC <= PC+1 and go to FETCH if run, else IDLE.

Boundary and timing rules:
- exec_done is ignored outside EXEC.
- exec_done in the same cycle as the issue_ready acceptance is ignored. Completion is counted only from EXEC.
- A branch target is ADDR_W bits of IR[11:8]; upper bits are ignored if ADDR_W < 4.
- PC+1 wraps from 15 to 0.
- Minimum cycles per instruction: jmp/br 2 (FETCH, DECODE); issued instructions 4 (FETCH, DECODE, ISSUE, EXEC), assuming ready and done arrive in the first cycle available.
- Dropping run mid-instruction never aborts it: the instruction completes and PC advances before IDLE is entered.
- A zero_flag change between DECODE cycles has no effect; only the value in DECODE matters.

Optional Feature:
- Macro: FETCH_SEQ_HALT_DETECT_EN.
- Defined: a jmp in DECODE whose target equals the current PC enters HALT instead of FETCH. In HALT, halted=1, busy=0, PC is frozen, and no issue occurs. Only rst leaves HALT.
- Undefined: the HALT state is not built, halted is tied to 0, and a self-jmp loops FETCH/DECODE indefinitely.

Test Plan:
- ROM[0]=load r7 3 (0x1E03); run=1, ready=1, exec_done one cycle after accept -> issue_inst=0x1E03 with issue_valid in cycle 3 after reset release; PC=1 after exec_done.
- ROM[4]=br 10 (0xCA00); zero_flag=1 in DECODE -> PC=10, no issue_valid pulse. Repeat with zero_flag=0 -> PC=5.
- issue_ready held low for 5 cycles -> issue_valid and issue_inst stay constant for all 5 cycles; exactly one acceptance; PC increments once.
- ROM[15]=add r1 r2 (0x2280), executed -> PC wraps to 0. Also: run dropped during EXEC -> instruction completes, then IDLE with PC=0 and busy=0.
- rst asserted during ISSUE with issue_valid=1 -> next edge: issue_valid=0, PC=0, IDLE. A late exec_done pulse is ignored.
- With FETCH_SEQ_HALT_DETECT_EN: ROM[11]=jmp 11 (0x8B00) -> halted=1 two cycles after reaching PC 11, PC stays 11. Without the macro -> halted=0 and FETCH/DECODE alternate.
